shared_tick_timer_arbiter: RTL and testbench
============================================

Name: shared_tick_timer_arbiter

Overview:
- Shares one CNT_W-bit up-counter timer among N_REQ requesters.
- Each requester asks for a delay of len+1 clock ticks; the block arbitrates round-robin, loads the terminal count, runs the counter, and returns a one-cycle done pulse to the winner.
- Sits between control FSMs that need timed waits and the single hardware counter resource, replacing per-client counters.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 8, counter width; max delay 2^CNT_W ticks.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous abort of the current timing; priority over all other inputs.
- req  input  N_REQ  per-requester request level; held until that requester's gnt rises.
- len  input  N_REQ*CNT_W  per-requester terminal count; slice i = len[i*CNT_W +: CNT_W]; sampled only at grant.
- gnt  output  N_REQ  one-hot grant, high while that requester's delay runs.
- done  output  N_REQ  one-cycle completion pulse to the granted requester.
- busy  output  1  high in RUN state.
- count  output  CNT_W  current counter value.

Behaviour:
- Reset (rst low, async): state IDLE; gnt=0; done=0; count=0; busy=0; round-robin pointer last=N_REQ-1, so requester 0 has highest priority first.
- All outputs are registered; no combinational input-to-output paths.
- FSM states: IDLE and RUN.
- IDLE:
  - done=0 unless set by the RUN exit on the same edge.
  - If any req bit is set, pick the first set bit scanning last+1, last+2, … modulo N_REQ.
  - Next edge: gnt one-hot to the winner idx; len_l <= len slice idx; count <= 0; last <= idx; state RUN; busy=1.
  - No req: stay IDLE.
- RUN:
  - Each edge, if count != len_l: count <= count+1.
  - If count == len_l: done[idx] <= 1 for one cycle; gnt <= 0; busy <= 0; count <= 0; state IDLE.
- Timing:
  - gnt is high exactly len_l+1 cycles.
  - done rises on the edge where gnt falls.
  - len=0 gives gnt for 1 cycle.
- Turnaround: the cycle showing done is an IDLE cycle that arbitrates. The next gnt rises one cycle after done, so there is a one-cycle gap between grants.
- Counter never exceeds len_l, so it never wraps. len=2^CNT_W-1 runs the full 2^CNT_W cycles.
- req deasserted while granted: ignored, timing completes normally.
- req of the granted requester held high after done: treated as a new request. Round-robin puts it last among the current requesters.
- len changes during RUN: ignored (len_l is latched).
- clr:
  - Next edge: state IDLE, gnt=0, count=0, busy=0, done=0.
  - No done pulse for the aborted request; last is unchanged.
  - clr held high blocks new grants.
- Simultaneous requests: exactly one grant; at most one gnt bit and at most one done bit high at any time.
- Reset mid-RUN: immediate return to reset values; no done pulse.

Test Plan:
- Reset then req=4'b0001, len0=3 → gnt=0001 for 4 cycles; count 0,1,2,3; done=0001 one cycle as gnt falls; busy matches gnt.
- req=4'b1111, all len=0 held → grants in order 0,1,2,3,0 with one-cycle gnt, done pulse each, one idle cycle between grants.
- req=4'b0101, len0=1, len2=2, req0 re-asserted after done → sequence 0,2,0; pointer fairness holds.
- req=0010, len1=255, CNT_W=8 → gnt high 256 cycles; count reaches 255 with no wrap; done at cycle 256.
- clr pulse when count=2 of len=5 → gnt=0, count=0, busy=0 next cycle; no done; pending req then granted.
- rst low asynchronously mid-RUN (count=3) → all outputs 0 without a clock edge; after release, requester 0 wins over 3 when both request.

Source files
------------

// File: rtl/shared_tick_timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shared_tick_timer_arbiter
//  Purpose  : One CNT_W-bit up-counter shared round-robin among N_REQ
//             requesters. A granted requester's delay runs for len+1 ticks.
//             The winner then receives a one-cycle done pulse.
//  Ports    : clk   - rising-edge clock
//             rst   - asynchronous active-low reset
//             clr   - synchronous abort of the current timing (highest priority)
//             req   - per-requester request level, held until its gnt rises
//             len   - per-requester terminal count, slice i at [i*CNT_W +: CNT_W]
//             gnt   - one-hot grant, high while the winner's delay runs
//             done  - one-cycle completion pulse to the winner
//             busy  - high while a delay is running
//             count - current counter value
//  Revision : 1.0 - initial release
// ============================================================================
module shared_tick_timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   len,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [CNT_W-1:0]         count
);

    localparam int                 c_IDX_W = $clog2(N_REQ);
    // One extra bit so that last+k (up to 2*N_REQ-1) cannot overflow.
    localparam logic [c_IDX_W:0]   c_N_EXT = (c_IDX_W+1)'(N_REQ);
    localparam logic [N_REQ-1:0]   c_ONE   = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       len_l_q, len_l_d;
    logic [c_IDX_W-1:0]     last_q, last_d;

    logic [CNT_W-1:0]       w_len_arr [N_REQ];
    logic                   w_found;
    logic [c_IDX_W-1:0]     w_win;
    logic [c_IDX_W:0]       w_cand;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len_slice
            assign w_len_arr[gi] = len[gi*CNT_W +: CNT_W];
        end
    endgenerate

    // Round-robin pick: scan last+1, last+2, ... modulo N_REQ, first set bit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = {1'b0, last_q} + (c_IDX_W+1)'(k);
            if (w_cand >= c_N_EXT) begin
                w_cand = w_cand - c_N_EXT;
            end
            if (!w_found && req[w_cand[c_IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        len_l_d = len_l_q;
        last_d  = last_q;

        if (clr) begin
            // Abort: no done pulse, pointer untouched.
            state_d = S_IDLE;
            gnt_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        state_d = S_RUN;
                        gnt_d   = c_ONE << w_win;
                        len_l_d = w_len_arr[w_win];
                        count_d = '0;
                        last_d  = w_win;
                    end
                end
                S_RUN: begin
                    if (count_q != len_l_q) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        // gnt_q is the winner's one-hot, reused as the done mask.
                        done_d  = gnt_q;
                        gnt_d   = '0;
                        count_d = '0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            len_l_q <= '0;
            last_q  <= c_IDX_W'(N_REQ-1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            len_l_q <= len_l_d;
            last_q  <= last_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign count = count_q;
    assign busy  = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_shared_tick_timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shared_tick_timer_arbiter
//  Purpose  : Scoreboard bench for shared_tick_timer_arbiter. Stimulus issues
//             requests and pushes predicted grant windows into a queue. A
//             monitor pops each window when the grant falls and compares it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shared_tick_timer_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           clr;
    logic [N-1:0]   req;
    logic [N*W-1:0] len;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count;

    shared_tick_timer_arbiter #(.N_REQ(N), .CNT_W(W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Predicted grant window: who, first edge showing gnt, and how many cycles.
    typedef struct {
        int idx;
        int g;
        int ncyc;
        bit aborted;
    } rec_t;

    rec_t         exp_q[$];
    int           n_chk  = 0;
    int           n_fail = 0;

    int           m_last;
    bit           m_active;
    int           m_run_end;
    logic [N-1:0] pend;
    bit           mon_en;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N*W-1:0] mk_len(input int a, input int b, input int c, input int d);
        logic [N*W-1:0] v;
        v = {W'(d), W'(c), W'(b), W'(a)};
        return v;
    endfunction

    function automatic logic [N*W-1:0] rnd_len();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0) v[i*W +: W] = W'($urandom_range(0, 255));
            else                             v[i*W +: W] = W'($urandom_range(0, 6));
        end
        return v;
    endfunction

    // Transaction model of what happens at clock edge P given the inputs driven for it.
    // A grant at edge P shows gnt for L+1 cycles; done appears after edge P+L+1, and
    // edge P+L+2 is the next one that can arbitrate.
    task automatic model_edge(input int P, input logic [N-1:0] r, input logic [N*W-1:0] lv,
                              input bit c, output int win);
        rec_t t;
        int   L;
        win = -1;
        if (m_active && P > m_run_end) m_active = 0;
        if (c) begin
            if (m_active && exp_q.size() > 0) begin
                t = exp_q[exp_q.size()-1];
                t.ncyc    = P - t.g;
                t.aborted = 1'b1;
                exp_q[exp_q.size()-1] = t;
            end
            m_active = 0;
        end else if (!m_active && r != '0) begin
            win = rr_pick(m_last, r);
            L   = int'(lv[win*W +: W]);
            t.idx = win; t.g = P; t.ncyc = L + 1; t.aborted = 1'b0;
            exp_q.push_back(t);
            m_last    = win;
            m_active  = 1;
            m_run_end = P + L + 1;
        end
    endtask

    task automatic step(input logic [N-1:0] add, input logic [N*W-1:0] lv, input bit c);
        int w;
        @(negedge clk); #1;
        pend = pend | add;
        req  = pend;
        len  = lv;
        clr  = c;
        model_edge(cyc + 1, pend, lv, c, w);
        if (w >= 0) pend[w] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            step('0, len, 1'b0);
            if (!m_active && pend == '0) return;
        end
        chk(1'b0, "drain_timeout", m_active, 0);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic [N-1:0] prev_gnt;
    int           run_cnt;
    int           rise_cyc;
    rec_t         mon_e;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_gnt = '0;
            run_cnt  = 0;
        end else begin
            chk(busy == (gnt != '0), "busy_vs_gnt", busy, gnt != '0);
            chk($onehot0(gnt) && $onehot0(done), "onehot_gnt_done", gnt, done);
            if (gnt != '0) begin
                if (prev_gnt == '0) begin
                    rise_cyc = cyc;
                    run_cnt  = 0;
                end else begin
                    chk(gnt == prev_gnt, "gnt_stable", gnt, prev_gnt);
                end
                chk(int'(count) == run_cnt, "count_value", count, run_cnt);
                chk(done == '0, "done_while_gnt", done, 0);
                run_cnt++;
            end else begin
                chk(count == '0, "count_idle", count, 0);
                if (prev_gnt != '0) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_grant", prev_gnt, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk(int'(prev_gnt) == (1 << mon_e.idx), "grant_idx", prev_gnt, 1 << mon_e.idx);
                        chk(rise_cyc == mon_e.g, "grant_start", rise_cyc, mon_e.g);
                        chk(run_cnt == mon_e.ncyc, "grant_len", run_cnt, mon_e.ncyc);
                        chk(int'(done) == (mon_e.aborted ? 0 : (1 << mon_e.idx)), "done_pulse",
                            done, mon_e.aborted ? 0 : (1 << mon_e.idx));
                    end
                end else begin
                    chk(done == '0, "done_spurious", done, 0);
                end
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; clr = 1'b0; req = '0; len = '0;
        pend = '0; mon_en = 1'b0; m_last = N - 1; m_active = 0; m_run_end = 0;

        repeat (3) @(negedge clk);
        chk(gnt == '0,   "reset_gnt",   gnt,   0);
        chk(done == '0,  "reset_done",  done,  0);
        chk(count == '0, "reset_count", count, 0);
        chk(busy == 1'b0, "reset_busy", busy,  0);
        #1 rst = 1'b1;
        mon_en = 1'b1;

        // Single requester, len 3.
        step(4'b0001, mk_len(3, 0, 0, 0), 1'b0);
        drain();

        // All requesting with len 0, re-asserted every cycle.
        for (int i = 0; i < 10; i++) step(4'b1111, mk_len(0, 0, 0, 0), 1'b0);
        drain();

        // 0 and 2, then 0 re-requests after its done.
        step(4'b0101, mk_len(1, 0, 2, 0), 1'b0);
        step(4'b0000, mk_len(1, 0, 2, 0), 1'b0);
        step(4'b0000, mk_len(1, 0, 2, 0), 1'b0);
        step(4'b0001, mk_len(1, 0, 2, 0), 1'b0);
        drain();

        // Full-range delay.
        step(4'b0010, mk_len(0, 255, 0, 0), 1'b0);
        drain();

        // Abort at count 2 of len 5 with another request pending; clr held a while.
        step(4'b0001, mk_len(5, 0, 4, 0), 1'b0);
        step(4'b0100, mk_len(5, 0, 4, 0), 1'b0);
        step(4'b0000, mk_len(5, 0, 4, 0), 1'b0);
        step(4'b0000, mk_len(5, 0, 4, 0), 1'b1);
        step(4'b0000, mk_len(5, 0, 4, 0), 1'b1);
        step(4'b0000, mk_len(5, 0, 4, 0), 1'b1);
        drain();

        // Randomized traffic with occasional aborts and changing len.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] add;
            add = N'($urandom & $urandom & $urandom);
            step(add, rnd_len(), $urandom_range(0, 63) == 0);
        end
        drain();

        // Asynchronous reset in the middle of a run.
        step(4'b0001, mk_len(10, 0, 0, 9), 1'b0);
        step(4'b1000, mk_len(10, 0, 0, 9), 1'b0);
        step(4'b0000, mk_len(10, 0, 0, 9), 1'b0);
        step(4'b0000, mk_len(10, 0, 0, 9), 1'b0);
        @(negedge clk);
        chk(count == W'(3), "count_before_reset", count, 3);
        #2;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk(gnt == '0,    "async_rst_gnt",   gnt,   0);
        chk(done == '0,   "async_rst_done",  done,  0);
        chk(count == '0,  "async_rst_count", count, 0);
        chk(busy == 1'b0, "async_rst_busy",  busy,  0);
        exp_q.delete();
        m_active = 0; m_last = N - 1; pend = '0; req = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;
        step(4'b1001, mk_len(2, 0, 0, 2), 1'b0);
        drain();

        chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
